// File: rtl/bgpu_pkg.sv
// bgpu_pkg: shared helpers for splitting an instruction id into warp id and per-warp tag
package bgpu_pkg;

    function automatic logic [31:0] iid_wid(input logic [31:0] iid, input int unsigned wid_w);
        return iid & ((32'd1 << wid_w) - 32'd1);
    endfunction

    function automatic logic [31:0] iid_tag(input logic [31:0] iid, input int unsigned wid_w);
        return iid >> wid_w;
    endfunction

endpackage

// File: rtl/rc_rr_arbiter.sv
// rc_rr_arbiter: round-robin pick of the first valid stream at or after ptr, wrapping
module rc_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxWidth = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]        valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    input  logic                en_i,
    output logic [N-1:0]        gnt_o,
    output logic [IdxWidth-1:0] idx_o
);
    logic [IdxWidth-1:0] hi, lo;
    logic                hi_f, lo_f;

    // lowest valid index at/after ptr (hi) and lowest valid overall (lo, the wrap case)
    always_comb begin
        hi   = '0;
        lo   = '0;
        hi_f = 1'b0;
        lo_f = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (valid_i[j]) begin
                lo   = IdxWidth'(j);
                lo_f = 1'b1;
            end
            if (valid_i[j] && j >= int'(ptr_i)) begin
                hi   = IdxWidth'(j);
                hi_f = 1'b1;
            end
        end
    end

    assign idx_o = hi_f ? hi : lo;
    assign gnt_o = (en_i && (hi_f || lo_f)) ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/result_collector.sv
// result_collector: round-robin writeback of EU results into one masked RF write port with tag release (optional BGPU_RC_PERF_CNT_EN retire counters)
module result_collector
    import bgpu_pkg::*;
#(
    parameter int unsigned NumEus      = 2,
    parameter int unsigned NumTags     = 8,
    parameter int unsigned RegWidth    = 32,
    parameter int unsigned WarpWidth   = 4,
    parameter int unsigned NumWarps    = 8,
    parameter int unsigned RegIdxWidth = 8,
    localparam int unsigned TagWidth   = $clog2(NumTags),
    localparam int unsigned WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1,
    localparam int unsigned IidWidth   = TagWidth + WidWidth,
    localparam int unsigned EuIdxWidth = NumEus > 1 ? $clog2(NumEus) : 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          testmode_i,
    input  logic [NumEus-1:0]                             eu_to_rc_valid_i,
    output logic [NumEus-1:0]                             rc_to_eu_ready_o,
    input  logic [NumEus-1:0][IidWidth-1:0]               eu_to_rc_tag_i,
    input  logic [NumEus-1:0][RegIdxWidth-1:0]            eu_to_rc_dst_i,
    input  logic [NumEus-1:0][WarpWidth-1:0]              eu_to_rc_act_mask_i,
    input  logic [NumEus-1:0][WarpWidth-1:0][RegWidth-1:0] eu_to_rc_data_i,
    output logic                                          rc_to_rf_valid_o,
    input  logic                                          rf_to_rc_ready_i,
    output logic [WidWidth-1:0]                           rc_to_rf_wid_o,
    output logic [RegIdxWidth-1:0]                        rc_to_rf_dst_o,
    output logic [WarpWidth-1:0]                          rc_to_rf_we_mask_o,
    output logic [WarpWidth-1:0][RegWidth-1:0]            rc_to_rf_data_o,
    output logic                                          rc_to_wb_valid_o,
    output logic [IidWidth-1:0]                           rc_to_wb_iid_o,
    output logic [NumEus-1:0][31:0]                       rc_perf_retired_o
);
    typedef struct packed {
        logic                              valid;
        logic [EuIdxWidth-1:0]             eu;
        logic [IidWidth-1:0]               tag;
        logic [RegIdxWidth-1:0]            dst;
        logic [WarpWidth-1:0]              mask;
        logic [WarpWidth-1:0][RegWidth-1:0] data;
    } entry_t;

    entry_t                e;
    logic [EuIdxWidth-1:0] rr_ptr, win;
    logic                  drain, accept_en, unused_sig;

    assign drain     = e.valid && (e.mask == '0 || rf_to_rc_ready_i);
    assign accept_en = rst_ni && (!e.valid || drain);

    rc_rr_arbiter #(.N(NumEus)) u_arb (
        .valid_i(eu_to_rc_valid_i),
        .ptr_i  (rr_ptr),
        .en_i   (accept_en),
        .gnt_o  (rc_to_eu_ready_o),
        .idx_o  (win)
    );

    // load the winner into the entry (possibly while draining), otherwise clear a drained entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e      <= '0;
            rr_ptr <= '0;
        end else if (|rc_to_eu_ready_o) begin
            e      <= '{valid: 1'b1, eu: win, tag: eu_to_rc_tag_i[win], dst: eu_to_rc_dst_i[win],
                        mask: eu_to_rc_act_mask_i[win], data: eu_to_rc_data_i[win]};
            rr_ptr <= (win == EuIdxWidth'(NumEus - 1)) ? '0 : win + 1'b1;
        end else if (drain) begin
            e <= '0;
        end
    end

    assign rc_to_rf_valid_o   = e.valid && |e.mask;
    assign rc_to_rf_wid_o     = WidWidth'(iid_wid(32'(e.tag), WidWidth));
    assign rc_to_rf_dst_o     = e.dst;
    assign rc_to_rf_we_mask_o = e.mask;
    assign rc_to_rf_data_o    = e.data;
    assign rc_to_wb_valid_o   = drain;
    assign rc_to_wb_iid_o     = drain ? e.tag : '0;
    assign unused_sig         = ^{testmode_i, e.eu};

`ifdef BGPU_RC_PERF_CNT_EN
    logic [NumEus-1:0][31:0] perf_q;

    // count retirements per originating EU, wrapping at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (drain) begin
            perf_q[e.eu] <= perf_q[e.eu] + 32'd1;
        end
    end

    assign rc_perf_retired_o = perf_q;
`else
    assign rc_perf_retired_o = '0;
`endif

endmodule
